// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: display-mode and control-FSM encodings shared across the stopwatch
package stopwatch_pkg;
  typedef enum logic [1:0] {
    MODE_LIVE   = 2'b00,
    MODE_SPLIT  = 2'b01,
    MODE_RECALL = 2'b10
  } mode_e;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } sw_state_e;
endpackage

// File: rtl/stopwatch_lap_ctrl_lap_buffer.sv
// lap_buffer: fill-once lap register file with count, full flag and async indexed read
module lap_buffer
  import stopwatch_pkg::*;
#(
  parameter int TIME_W = 16,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [TIME_W-1:0] wdata_i,
  input  logic [AW-1:0]     rd_idx_i,
  output logic [TIME_W-1:0] rdata_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o
);
  logic [TIME_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              we;
  assign full_o  = count_q == CW'(DEPTH);
  assign we      = wr_i && !clr_i && !full_o;
  assign rdata_o = mem_q[rd_idx_i];
  assign count_o = count_q;
  always_comb begin
    wr_ptr_d = clr_i ? '0 : we ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = clr_i ? '0 : we ? count_q + CW'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage is never reset; count gates every read path
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: lap capture, split hold, lap recall and display-source selection
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TIME_W      = 16,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 200000000,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1,
  localparam int TW         = $clog2(HOLD_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              clear_i,
  input  logic              lap_i,
  input  logic              recall_i,
  input  logic [TIME_W-1:0] time_i,
  output logic [TIME_W-1:0] disp_time_o,
  output logic [1:0]        mode_o,
  output logic [CW-1:0]     lap_count_o,
  output logic [AW-1:0]     rd_idx_o,
  output logic              lap_drop_o
);
  mode_e             mode_q, mode_d;
  logic [TIME_W-1:0] disp_q, disp_d;
  logic [AW-1:0]     rd_idx_q, rd_idx_d, rd_sel;
  logic [TW-1:0]     timer_q, timer_d;
  logic              drop_q, drop_d;
  logic              lap_ok, rec_ok, full, more;
  logic [TIME_W-1:0] rdata;
  logic [CW-1:0]     count;
  assign lap_ok = lap_i && run_i && mode_q != MODE_RECALL;
  assign rec_ok = recall_i && !run_i;
  assign more   = CW'(rd_idx_q) + CW'(1) < count;
  // in RECALL the read port already looks one entry ahead for the next press
  assign rd_sel = (mode_q == MODE_RECALL) ? rd_idx_q + AW'(1) : '0;
  lap_buffer #(.TIME_W(TIME_W), .DEPTH(DEPTH)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clear_i),
    .wr_i     (lap_ok),
    .wdata_i  (time_i),
    .rd_idx_i (rd_sel),
    .rdata_o  (rdata),
    .count_o  (count),
    .full_o   (full)
  );
  always_comb begin
    mode_d   = mode_q;
    disp_d   = disp_q;
    rd_idx_d = rd_idx_q;
    timer_d  = timer_q;
    drop_d   = !clear_i && lap_ok && full;
    if (clear_i) begin
      mode_d   = MODE_LIVE;
      rd_idx_d = '0;
      timer_d  = '0;
    end else if (lap_ok && !full) begin
      mode_d  = MODE_SPLIT;
      disp_d  = time_i;
      timer_d = TW'(HOLD_CYCLES - 1);
    end else if (rec_ok && mode_q == MODE_RECALL) begin
      mode_d   = more ? MODE_RECALL : MODE_LIVE;
      rd_idx_d = more ? rd_idx_q + AW'(1) : '0;
      disp_d   = rdata;
    end else if (rec_ok && count != '0) begin
      mode_d   = MODE_RECALL;
      rd_idx_d = '0;
      disp_d   = rdata;
      timer_d  = '0;
    end else if (mode_q == MODE_SPLIT) begin
      mode_d  = (timer_q == '0) ? MODE_LIVE : MODE_SPLIT;
      timer_d = (timer_q == '0) ? '0 : timer_q - TW'(1);
    end else if (mode_q == MODE_RECALL && run_i) begin
      mode_d   = MODE_LIVE;
      rd_idx_d = '0;
    end
    if (mode_d == MODE_LIVE) disp_d = time_i;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= MODE_LIVE;
      disp_q   <= '0;
      rd_idx_q <= '0;
      timer_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      disp_q   <= disp_d;
      rd_idx_q <= rd_idx_d;
      timer_q  <= timer_d;
      drop_q   <= drop_d;
    end
  end
  assign disp_time_o = disp_q;
  assign mode_o      = mode_q;
  assign lap_count_o = count;
  assign rd_idx_o    = rd_idx_q;
  assign lap_drop_o  = drop_q;
endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
Lap/split controller sitting beside the stopwatch control FSM and time counter. It captures the live time into a small lap buffer on LAP presses while running, freezes the display on the captured split for a hold period, and lets the user browse stored laps while the watch is stopped. It owns the display-source selection between live time, split and recalled lap, and drives the display decoder.

Parameters:
TIME_W, 16, width of the time word from the counter (BCD mm:ss, opaque to this block)
DEPTH, 4, number of lap entries (power of 2, >=2)
HOLD_CYCLES, 200000000, clock cycles a split stays frozen on the display (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
run  input  1  enable from control FSM; 1 = counter running
clear  input  1  user reset pulse (same pulse that forces the FSM to IDLE)
lap  input  1  single-cycle lap request (already debounced/edge-detected)
recall  input  1  single-cycle recall/next request
time_in  input  TIME_W  live time from counter
disp_time  output  TIME_W  registered time word for display
mode  output  2  00=LIVE, 01=SPLIT, 10=RECALL
lap_count  output  clog2(DEPTH)+1  number of stored laps, 0..DEPTH
rd_idx  output  clog2(DEPTH)  index shown in RECALL, else 0
lap_drop  output  1  one-cycle pulse: lap request rejected because buffer full

Behaviour:
- Reset: sampled on posedge clk when rst_n=0. Outputs: disp_time=0, mode=LIVE, lap_count=0, rd_idx=0, lap_drop=0; write pointer=0. Buffer contents need no reset, but are unreadable while lap_count=0.
- All outputs registered. In LIVE, disp_time = time_in from the previous edge (1-cycle latency).
- Priority per edge: rst_n > clear > lap > recall > hold-timer expiry / run change.
- clear: empty the buffer (lap_count=0, write ptr=0), mode=LIVE, rd_idx=0, hold timer=0. lap/recall in the same cycle are ignored.
- lap is accepted only when run=1 and mode != RECALL:
  - lap_count<DEPTH: buf[wr_ptr]<=time_in; wr_ptr++; lap_count++; mode<=SPLIT; disp_time<=time_in; hold timer<=HOLD_CYCLES-1.
  - lap_count==DEPTH: no write, lap_drop=1 for one cycle, mode/display unchanged.
  - lap while already in SPLIT: captures a new split and reloads the timer.
- SPLIT: the hold timer decrements each cycle. When the timer=0, mode<=LIVE and display returns to live on the next edge. So the split is shown for exactly HOLD_CYCLES cycles. If run falls during SPLIT, stay in SPLIT until the timer expires.
- lap while run=0: ignored silently (no lap_drop).
- recall is accepted only when run=0:
  - From LIVE/SPLIT with lap_count>0: mode<=RECALL, rd_idx<=0, disp_time<=buf[0], timer cleared.
  - In RECALL: if rd_idx<lap_count-1, rd_idx++ and disp_time<=buf[rd_idx+1]. Otherwise mode<=LIVE and rd_idx<=0.
  - recall with lap_count=0, or with run=1: ignored.
- RECALL and run rises: mode<=LIVE, rd_idx<=0 on the next edge.
- lap and recall cannot both be legal in one cycle (run gates them exclusively). If both are asserted, the run-legal one acts.
- No wrap of wr_ptr into valid data: the buffer fills and stops, never overwrites.
- The hold timer is wide enough for HOLD_CYCLES-1 (clog2). It never underflows.

Decomposition:
- Shared package stopwatch_pkg: mode encodings (MODE_LIVE/SPLIT/RECALL) and the FSM status encodings (IDLE/RUNNING/PAUSED), so the display mux and FSM agree.
- One natural sub-module: lap_buffer (DEPTH x TIME_W register file with write pointer, count, full flag and async read by index).
- Mode FSM, hold timer and display mux stay in the top.

Test Plan:
1. Reset/LIVE: rst_n=0 for 2 cycles with time_in=16'h0123, then release -> all outputs 0 during reset; one cycle after release disp_time=16'h0123, mode=00.
2. Split hold (HOLD_CYCLES=8): run=1, time_in=16'h0042, pulse lap -> next edge mode=01, disp_time=16'h0042, lap_count=1. Display stays 16'h0042 while time_in advances for 8 cycles, then mode=00 and live time shown.
3. Full buffer: 4 laps at time_in 0x0010/0x0020/0x0030/0x0040, then a 5th lap -> lap_count=4, lap_drop=1 for exactly one cycle, no overwrite of buf[3]=0x0040.
4. Recall walk: after test 3, run=0, 5 recall pulses -> disp_time 0x0010,0x0020,0x0030,0x0040 with rd_idx 0..3, then mode=00, rd_idx=0. recall with lap_count=0 -> no change.
5. Run during recall: mode=10, rd_idx=2, raise run -> next edge mode=00, rd_idx=0, lap_count unchanged.
6. Clear collision: clear and lap in the same cycle with run=1, lap_count=2 -> lap_count=0, mode=00, no write, lap_drop=0. Same-cycle rst_n=0 with clear -> reset values.
